// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - op encoding and per-stage control record for pipe_adder
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic valid;
        logic op;
        logic carry;
    } ctrl_t;

    // 1 when operand B must be complemented before it enters the ripple chain
    function automatic logic b_invert(input logic op);
        case (op)
            OP_ADD:  b_invert = 1'b0;
            OP_SUB:  b_invert = 1'b1;
            default: b_invert = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg_adder.sv
// rtl/seg_adder.sv - SEG-bit combinational ripple-carry adder built from full-adder equations
module seg_adder #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    logic w_c;

    always_comb begin
        s   = '0;
        w_c = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined adder/subtractor, one register stage per SEG-bit carry segment
// Signed overflow output is built only when PIPE_ADDER_OVF_EN is defined; otherwise ovf is tied low.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    import adder_pkg::*;

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    ctrl_t            r_ctrl [STAGES];
    logic [WIDTH-1:0] r_sum  [STAGES];
    logic [WIDTH-1:0] r_a    [STAGES];
    logic [WIDTH-1:0] r_b    [STAGES];

    ctrl_t            w_ctrl_in  [STAGES];
    logic [WIDTH-1:0] w_a_in     [STAGES];
    logic [WIDTH-1:0] w_b_in     [STAGES];
    logic [WIDTH-1:0] w_sum_in   [STAGES];
    logic [WIDTH-1:0] w_sum_next [STAGES];
    logic [SEG-1:0]   w_seg_b    [STAGES];
    logic [SEG-1:0]   w_seg_s    [STAGES];
    logic             w_seg_co   [STAGES];
    logic             w_adv;

    assign w_adv     = !r_ctrl[LAST].valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_ctrl[LAST].valid;
    assign s         = r_sum[LAST];
    assign co        = r_ctrl[LAST].carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_ctrl_in[k] = '{valid: in_valid, op: op, carry: ci};
            assign w_a_in[k]    = a;
            assign w_b_in[k]    = b;
            assign w_sum_in[k]  = '0;
        end else begin : g_body
            assign w_ctrl_in[k] = r_ctrl[k-1];
            assign w_a_in[k]    = r_a[k-1];
            assign w_b_in[k]    = r_b[k-1];
            assign w_sum_in[k]  = r_sum[k-1];
        end

        // B travels raw down the pipe; each stage complements only its own segment
        assign w_seg_b[k] = w_b_in[k][k*SEG +: SEG] ^ {SEG{b_invert(w_ctrl_in[k].op)}};

        seg_adder #(.SEG(SEG)) u_seg (
            .a  (w_a_in[k][k*SEG +: SEG]),
            .b  (w_seg_b[k]),
            .ci (w_ctrl_in[k].carry),
            .s  (w_seg_s[k]),
            .co (w_seg_co[k])
        );

        // segment k of the incoming partial sum is still zero, so OR merges it in
        assign w_sum_next[k] = w_sum_in[k] | (WIDTH'(w_seg_s[k]) << (k * SEG));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_ctrl[i] <= '0;
                r_sum[i]  <= '0;
                r_a[i]    <= '0;
                r_b[i]    <= '0;
            end
        end else if (w_adv) begin
            for (int i = 0; i < STAGES; i++) begin
                r_ctrl[i] <= '{valid: w_ctrl_in[i].valid, op: w_ctrl_in[i].op, carry: w_seg_co[i]};
                r_sum[i]  <= w_sum_next[i];
                r_a[i]    <= w_a_in[i];
                r_b[i]    <= w_b_in[i];
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic r_ovf;
    logic w_sign_a;
    logic w_sign_b;
    logic w_ovf_next;

    assign w_sign_a   = w_a_in[LAST][WIDTH-1];
    assign w_sign_b   = w_seg_b[LAST][SEG-1];
    assign w_ovf_next = (w_sign_a == w_sign_b) && (w_seg_s[LAST][SEG-1] != w_sign_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf_next;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder at 16/4, 32/8 and 8/8
module tb_pipe_adder;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q0[$];
    exp_t qw[$];
    exp_t qn[$];
    exp_t e0, ew, en;

    // 16/4 instance
    logic        in_valid0, out_ready0, ci0, op0;
    logic [15:0] a0, b0;
    logic        in_ready0, out_valid0, co0, ovf0;
    logic [15:0] s0;
    // 32/8 instance
    logic        in_valid_w, out_ready_w, ci_w, op_w;
    logic [31:0] a_w, b_w;
    logic        in_ready_w, out_valid_w, co_w, ovf_w;
    logic [31:0] s_w;
    // 8/8 instance
    logic        in_valid_n, out_ready_n, ci_n, op_n;
    logic [7:0]  a_n, b_n;
    logic        in_ready_n, out_valid_n, co_n, ovf_n;
    logic [7:0]  s_n;

    pipe_adder #(.WIDTH(16), .SEG(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .ci(ci0), .op(op0), .out_valid(out_valid0),
        .out_ready(out_ready0), .s(s0), .co(co0), .ovf(ovf0)
    );

    pipe_adder #(.WIDTH(32), .SEG(8)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .ci(ci_w), .op(op_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .s(s_w), .co(co_w), .ovf(ovf_w)
    );

    pipe_adder #(.WIDTH(8), .SEG(8)) u_dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
        .a(a_n), .b(b_n), .ci(ci_n), .op(op_n), .out_valid(out_valid_n),
        .out_ready(out_ready_n), .s(s_n), .co(co_n), .ovf(ovf_n)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    function automatic logic eov(input logic v);
`ifdef PIPE_ADDER_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic o);
        exp_t        e;
        logic [31:0] mask;
        logic [31:0] bb;
        logic [32:0] full;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bb    = (o ? ~b : b) & mask;
        full  = {1'b0, a & mask} + {1'b0, bb} + {32'd0, c};
        e.s   = full[31:0] & mask;
        e.co  = full[w];
        e.ovf = eov((a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]));
        e.acc = 0;
        e.lat = 1'b1;
        return e;
    endfunction

    // ---------------- monitors ----------------
    bit          lat_done0  = 1'b0;
    bit          stall_prev = 1'b0;
    logic [15:0] prev_s0;

    always @(negedge clk) begin
        if (rst) begin
            lat_done0  = 1'b0;
            stall_prev = 1'b0;
        end else if (out_valid0) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out0: got s=%h with nothing expected", s0);
            end else begin
                if (q0[0].lat && !lat_done0) begin
                    check("latency0", 32'(cycle - q0[0].acc), 32'd4);
                    lat_done0 = 1'b1;
                end
                if (!out_ready0) begin
                    check("stall_in_ready", 32'(in_ready0), 32'd0);
                    if (stall_prev) check("stall_s_hold", 32'(s0), 32'(prev_s0));
                    stall_prev = 1'b1;
                    prev_s0    = s0;
                end else begin
                    e0 = q0.pop_front();
                    check("s0", 32'(s0), e0.s);
                    check("co0", 32'(co0), 32'(e0.co));
                    check("ovf0", 32'(ovf0), 32'(e0.ovf));
                    lat_done0  = 1'b0;
                    stall_prev = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_w) begin
            if (qw.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_w: got s=%h with nothing expected", s_w);
            end else begin
                ew = qw.pop_front();
                if (ew.lat) check("latency_w", 32'(cycle - ew.acc), 32'd4);
                check("s_w", s_w, ew.s);
                check("co_w", 32'(co_w), 32'(ew.co));
                check("ovf_w", 32'(ovf_w), 32'(ew.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_n) begin
            if (qn.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_n: got s=%h with nothing expected", s_n);
            end else begin
                en = qn.pop_front();
                if (en.lat) check("latency_n", 32'(cycle - en.acc), 32'd1);
                check("s_n", 32'(s_n), en.s);
                check("co_n", 32'(co_n), 32'(en.co));
                check("ovf_n", 32'(ovf_n), 32'(en.ovf));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic c, input logic o,
                         input logic [15:0] es, input logic eco, input logic eovf, input bit lat);
        int   n = 0;
        exp_t e;
        a0 = a; b0 = b; ci0 = c; op0 = o; in_valid0 = 1'b1;
        while (!in_ready0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send0_timeout: in_ready stayed 0, required 1");
        end
        e.s = 32'(es); e.co = eco; e.ovf = eov(eovf); e.acc = cycle; e.lat = lat;
        q0.push_back(e);
        @(posedge clk); #2;
    endtask

    task automatic idle0(input int n);
        in_valid0 = 1'b0;
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic send_w(input logic [31:0] a, input logic [31:0] b, input logic c, input logic o,
                          input exp_t e_in);
        exp_t e;
        a_w = a; b_w = b; ci_w = c; op_w = o; in_valid_w = 1'b1;
        check("in_ready_w", 32'(in_ready_w), 32'd1);
        e = e_in; e.acc = cycle; e.lat = 1'b1;
        qw.push_back(e);
        @(posedge clk); #2;
        in_valid_w = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] a, input logic [7:0] b, input logic c, input logic o,
                          input exp_t e_in);
        exp_t e;
        a_n = a; b_n = b; ci_n = c; op_n = o; in_valid_n = 1'b1;
        check("in_ready_n", 32'(in_ready_n), 32'd1);
        e = e_in; e.acc = cycle; e.lat = 1'b1;
        qn.push_back(e);
        @(posedge clk); #2;
        in_valid_n = 1'b0;
    endtask

    function automatic exp_t hand(input logic [31:0] es, input logic eco, input logic eovf);
        exp_t e;
        e.s = es; e.co = eco; e.ovf = eov(eovf); e.acc = 0; e.lat = 1'b1;
        return e;
    endfunction

    // stream table: a, b, op, ci, s, co, ovf
    logic [15:0] st_a  [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h0010, 16'h0000, 16'h4000, 16'h7FFF};
    logic [15:0] st_b  [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h4000, 16'hFFFF};
    logic        st_op [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] st_s  [8] = '{16'h0002, 16'h0100, 16'h1000, 16'h0000, 16'h000F, 16'hFFFF, 16'h8000, 16'h8000};
    logic        st_co [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        st_ov [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] ra, rb;
        logic        rc, ro;

        rst = 1'b1;
        in_valid0 = 1'b0; out_ready0 = 1'b1; a0 = '0; b0 = '0; ci0 = 1'b0; op0 = 1'b0;
        in_valid_w = 1'b0; out_ready_w = 1'b1; a_w = '0; b_w = '0; ci_w = 1'b0; op_w = 1'b0;
        in_valid_n = 1'b0; out_ready_n = 1'b1; a_n = '0; b_n = '0; ci_n = 1'b0; op_n = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        check("rst_s", 32'(s0), 32'd0);
        check("rst_co", 32'(co0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_out_valid_w", 32'(out_valid_w), 32'd0);
        check("rst_out_valid_n", 32'(out_valid_n), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #2;

        // parameter sweep: directed vectors then random operands against the model
        fork
            begin
                send_w(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, hand(32'h0000_0000, 1'b1, 1'b0));
                send_w(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, hand(32'h9999_9999, 1'b0, 1'b0));
                send_w(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, hand(32'hFFFF_FFFF, 1'b0, 1'b0));
                send_w(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, hand(32'h8000_0000, 1'b0, 1'b1));
                for (int i = 0; i < 8; i++) begin
                    ra = $urandom; rb = $urandom;
                    rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
                    send_w(ra, rb, rc, ro, model(32, ra, rb, rc, ro));
                end
            end
            begin
                send_n(8'hFF, 8'h01, 1'b0, 1'b0, hand(32'h00, 1'b1, 1'b0));
                send_n(8'h05, 8'h07, 1'b1, 1'b1, hand(32'hFE, 1'b0, 1'b0));
                send_n(8'h7F, 8'h01, 1'b0, 1'b0, hand(32'h80, 1'b0, 1'b1));
                send_n(8'h80, 8'h01, 1'b1, 1'b1, hand(32'h7F, 1'b1, 1'b1));
                for (int i = 0; i < 8; i++) begin
                    ra = $urandom; rb = $urandom;
                    rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
                    send_n(ra[7:0], rb[7:0], rc, ro, model(8, {24'd0, ra[7:0]}, {24'd0, rb[7:0]}, rc, ro));
                end
            end
        join
        repeat (6) begin
            @(posedge clk); #2;
        end

        // isolated directed vectors on the default configuration
        send0(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1); idle0(5);
        send0(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); idle0(5);
        send0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1); idle0(5);
        send0(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1); idle0(5);
        send0(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1); idle0(5);
        send0(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1); idle0(5);
        send0(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1); idle0(5);
        send0(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1); idle0(5);

        // back-to-back stream with a 3-cycle downstream stall in the middle
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send0(st_a[i], st_b[i], st_op[i], st_op[i], st_s[i], st_co[i], st_ov[i], 1'b0);
                idle0(1);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready0 = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready0 = 1'b1;
            end
        join
        idle0(8);

        // reset while three beats are in flight, the oldest stalled at the output
        out_ready0 = 1'b0;
        send0(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0);
        send0(16'h2222, 16'h2222, 1'b0, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0);
        send0(16'h3333, 16'h3333, 1'b0, 1'b0, 16'h6666, 1'b0, 1'b0, 1'b0);
        in_valid0 = 1'b0;
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("flight_reached_out", 32'(out_valid0), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_out_valid", 32'(out_valid0), 32'd0);
        check("rst_async_in_ready", 32'(in_ready0), 32'd1);
        check("rst_async_s", 32'(s0), 32'd0);
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready0 = 1'b1;
        #1;
        idle0(8);
        send0(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        idle0(2);

        n = 0;
        while ((q0.size() != 0 || qw.size() != 0 || qn.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        check("pending_results", 32'(q0.size() + qw.size() + qn.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
